// File: rtl/alu_muldiv_control_if.sv
// Bundle of decode inputs, multiply/divide launch signals and results
// shared between the ALU/MUL-DIV control block and whoever drives it.
interface alu_muldiv_control_if #(
   parameter int XLEN = 32
) ();
   logic            start;
   logic [6:0]      instruction_opcode;
   logic [2:0]      func3;
   logic [6:0]      func7;
   logic [1:0]      aluop_in;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic [3:0]      aluop_out;
   logic            is_muldiv;
   logic            md_busy;
   logic            md_done;
   logic [XLEN-1:0] md_result;

   // Requester side: drives instruction fields and operands.
   modport master (
      output start, instruction_opcode, func3, func7, aluop_in, rs1, rs2,
      input  aluop_out, is_muldiv, md_busy, md_done, md_result
   );

   // Control block side.
   modport slave (
      input  start, instruction_opcode, func3, func7, aluop_in, rs1, rs2,
      output aluop_out, is_muldiv, md_busy, md_done, md_result
   );
endinterface

// File: rtl/alu_muldiv_control.sv
// ALU control decoder plus an iterative multiply/divide unit.
// Single-cycle ALU opcodes are decoded combinationally; M-extension ops run
// one bit per cycle (shift-add multiply, restoring divide) on operand
// magnitudes, with the sign fixed up once the iteration is finished.
module alu_muldiv_control #(
   parameter int XLEN = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   alu_muldiv_control_if.slave  bus
);
   localparam int CW = $clog2(XLEN);

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SRA  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_XOR  = 4'b1010;
   localparam logic [3:0] ALU_SLTU = 4'b1101;
   localparam logic [3:0] ALU_BNE  = 4'b1110;

   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_REG    = 7'b0110011;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t              state_reg, state_next;
   logic [CW-1:0]       count_reg;
   logic [2*XLEN-1:0]   acc_reg;     // {high/remainder, low/quotient}
   logic [XLEN-1:0]     b_reg;       // multiplicand or divisor magnitude
   logic [2:0]          func3_reg;
   logic                neg_reg;     // negate the selected result at the end
   logic                busy_reg, done_reg;
   logic [XLEN-1:0]     result_reg;

   // Shared arithmetic decode for immediate and register-register forms.
   function automatic logic [3:0] dec_arith(input logic [2:0] f3, input logic alt);
      logic [3:0] code;
      case (f3)
         3'b000:  code = ALU_ADD;
         3'b001:  code = ALU_SLL;
         3'b010:  code = ALU_SLT;
         3'b011:  code = ALU_SLTU;
         3'b100:  code = ALU_XOR;
         3'b101:  code = alt ? ALU_SRA : ALU_SRL;
         3'b110:  code = ALU_OR;
         default: code = ALU_AND;
      endcase
      return code;
   endfunction

   logic is_md;
   logic [3:0] aluop;

   // Single-cycle ALU operation decode; anything unrecognised falls back to ADD.
   always_comb begin
      aluop = ALU_ADD;
      is_md = (bus.instruction_opcode == OPC_REG) && (bus.func7 == 7'b0000001);
      if (bus.aluop_in != 2'b00) begin
         case (bus.instruction_opcode)
            OPC_IMM: aluop = dec_arith(bus.func3, bus.func7[5]);
            OPC_BRANCH: begin
               case (bus.func3)
                  3'b000:          aluop = ALU_SUB;
                  3'b001:          aluop = ALU_BNE;
                  3'b100, 3'b101:  aluop = ALU_SLT;
                  3'b110, 3'b111:  aluop = ALU_SLTU;
                  default:         aluop = ALU_SUB;
               endcase
            end
            OPC_REG: begin
               if (bus.func7 == 7'b0000000 || bus.func7 == 7'b0100000) begin
                  if (bus.func3 == 3'b000)
                     aluop = bus.func7[5] ? ALU_SUB : ALU_ADD;
                  else
                     aluop = dec_arith(bus.func3, bus.func7[5]);
               end
            end
            default: aluop = ALU_ADD;
         endcase
      end
   end

   assign bus.aluop_out = aluop;
   assign bus.is_muldiv = is_md;

   // Launch-time operand preparation.
   logic            accept, md_div, div_zero, div_ovf, skip;
   logic            a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;

   assign accept   = (state_reg == IDLE) && bus.start && is_md;
   assign md_div   = bus.func3[2];
   assign div_zero = md_div && (bus.rs2 == '0);
   assign div_ovf  = md_div && !bus.func3[0]
                     && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
   assign skip     = div_zero || div_ovf;
   assign a_signed = md_div ? !bus.func3[0]
                            : (bus.func3[1:0] == 2'b01 || bus.func3[1:0] == 2'b10);
   assign b_signed = md_div ? !bus.func3[0] : (bus.func3[1:0] == 2'b01);
   assign a_neg    = a_signed && bus.rs1[XLEN-1];
   assign b_neg    = b_signed && bus.rs2[XLEN-1];
   assign a_mag    = a_neg ? -bus.rs1 : bus.rs1;
   assign b_mag    = b_neg ? -bus.rs2 : bus.rs2;

   // One iteration step for each operation.
   logic [XLEN:0]     mul_sum, div_shift;
   logic [XLEN-1:0]   div_diff;
   logic              div_ge;
   logic [2*XLEN-1:0] mul_step, div_step;
   logic              last_iter;

   assign mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, b_reg & {XLEN{acc_reg[0]}}};
   assign mul_step  = {mul_sum, acc_reg[XLEN-1:1]};
   assign div_shift = acc_reg[2*XLEN-1:XLEN-1];
   assign div_ge    = div_shift >= {1'b0, b_reg};
   assign div_diff  = div_shift[XLEN-1:0] - b_reg;
   assign div_step  = div_ge ? {div_diff, acc_reg[XLEN-2:0], 1'b1}
                             : {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
   assign last_iter = (count_reg == CW'(XLEN - 1));

   // Final sign fix-up and result selection.
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   div_sel, final_result;

   assign prod         = neg_reg ? -acc_reg : acc_reg;
   assign div_sel      = func3_reg[1] ? acc_reg[2*XLEN-1:XLEN] : acc_reg[XLEN-1:0];
   assign final_result = func3_reg[2] ? (neg_reg ? -div_sel : div_sel)
                       : (func3_reg[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = skip ? DONE : (md_div ? DIV : MUL);
         MUL:  if (last_iter) state_next = DONE;
         DIV:  if (last_iter) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand latching and iteration datapath; special divides preload the answer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_reg <= '0;
         acc_reg   <= '0;
         b_reg     <= '0;
         func3_reg <= '0;
         neg_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  func3_reg <= bus.func3;
                  count_reg <= '0;
                  b_reg     <= b_mag;
                  if (div_zero) begin
                     acc_reg <= {bus.rs1, {XLEN{1'b1}}};
                     neg_reg <= 1'b0;
                  end else if (div_ovf) begin
                     acc_reg <= {{XLEN{1'b0}}, bus.rs1};
                     neg_reg <= 1'b0;
                  end else begin
                     acc_reg <= {{XLEN{1'b0}}, a_mag};
                     neg_reg <= (md_div && bus.func3[1]) ? a_neg : (a_neg ^ b_neg);
                  end
               end
            end
            MUL: begin
               acc_reg   <= mul_step;
               count_reg <= count_reg + 1'b1;
            end
            DIV: begin
               acc_reg   <= div_step;
               count_reg <= count_reg + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Registered status and result outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         result_reg <= '0;
      end else begin
         busy_reg <= (state_next == MUL) || (state_next == DIV);
         done_reg <= (state_reg == DONE);
         if (state_reg == DONE) result_reg <= final_result;
      end
   end

   assign bus.md_busy   = busy_reg;
   assign bus.md_done   = done_reg;
   assign bus.md_result = result_reg;
endmodule

// File: tb/tb_alu_muldiv_control.sv
// Randomized bench for alu_muldiv_control against a plain-arithmetic model.
module tb_alu_muldiv_control;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   alu_muldiv_control_if #(.XLEN(XLEN)) bus ();
   alu_muldiv_control #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;

   // Expected single-cycle ALU code, from the decode tables.
   function automatic logic [3:0] model_alu(input logic [1:0] aop, input logic [6:0] opc,
                                            input logic [2:0] f3, input logic [6:0] f7);
      logic [3:0] arith [8];
      logic [3:0] br [8];
      arith = '{4'b0010, 4'b1000, 4'b0111, 4'b1101, 4'b1010, 4'b1001, 4'b0001, 4'b0000};
      br    = '{4'b0110, 4'b1110, 4'b0110, 4'b0110, 4'b0111, 4'b0111, 4'b1101, 4'b1101};
      if (aop == 2'b00) return 4'b0010;
      if (opc == 7'h13) begin
         if (f3 == 3'd5 && f7[5]) return 4'b0011;
         return arith[f3];
      end
      if (opc == 7'h63) return br[f3];
      if (opc == 7'h33 && (f7 == 7'h00 || f7 == 7'h20)) begin
         if (f7[5] && f3 == 3'd0) return 4'b0110;
         if (f7[5] && f3 == 3'd5) return 4'b0011;
         return arith[f3];
      end
      return 4'b0010;
   endfunction

   // Expected M-extension result using wide native arithmetic.
   function automatic logic [31:0] model_md(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic [63:0] ua, ub, p;
      logic ovf;
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      ua = {32'b0, a};
      ub = {32'b0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * $signed(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            return $signed(a) / $signed(b);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit model_short(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Launch one multi-cycle op and observe it for a fixed window.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int pulse_at, output logic [31:0] res, output logic [31:0] res_end,
                         output int lat, output int busy_cnt, output int done_cnt);
      lat = -1; busy_cnt = 0; done_cnt = 0; res = '0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.instruction_opcode = 7'h33;
      bus.func7 = 7'h01;
      bus.func3 = f3;
      bus.aluop_in = 2'b10;
      bus.rs1 = a;
      bus.rs2 = b;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.rs1 = $urandom;
      bus.rs2 = $urandom;
      if (bus.md_busy) busy_cnt++;
      for (int k = 1; k <= XLEN + 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         bus.start = (k == pulse_at);
         if (bus.md_busy) busy_cnt++;
         if (bus.md_done) begin
            done_cnt++;
            if (lat < 0) begin
               lat = k;
               res = bus.md_result;
            end
         end
      end
      bus.start = 1'b0;
      res_end = bus.md_result;
      $display("op f3=%0d a=%h b=%h result=%h latency=%0d busy=%0d dones=%0d",
               f3, a, b, res, lat, busy_cnt, done_cnt);
   endtask

   // Runs one op and compares every observable against the model.
   task automatic check_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input int pulse_at);
      logic [31:0] res, res_end, exp_res;
      int lat, busy_cnt, done_cnt, exp_lat, exp_busy;
      exp_res  = model_md(f3, a, b);
      exp_lat  = model_short(f3, a, b) ? 1 : XLEN + 1;
      exp_busy = model_short(f3, a, b) ? 0 : XLEN;
      run_op(f3, a, b, pulse_at, res, res_end, lat, busy_cnt, done_cnt);
      checks += 5;
      if (res !== exp_res) begin
         errors++; $display("FAIL %s result got %h want %h", name, res, exp_res);
      end
      if (lat != exp_lat) begin
         errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
      end
      if (busy_cnt != exp_busy) begin
         errors++; $display("FAIL %s busy_cycles got %0d want %0d", name, busy_cnt, exp_busy);
      end
      if (done_cnt != 1) begin
         errors++; $display("FAIL %s done_pulses got %0d want 1", name, done_cnt);
      end
      if (res_end !== exp_res) begin
         errors++; $display("FAIL %s result_hold got %h want %h", name, res_end, exp_res);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.start = 1'b1;
      bus.instruction_opcode = 7'h33;
      bus.func7 = 7'h01;
      bus.func3 = 3'd0;
      bus.aluop_in = 2'b10;
      bus.rs1 = 32'd3;
      bus.rs2 = 32'd5;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks += 3;
      if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.md_busy); end
      if (bus.md_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.md_done); end
      if (bus.md_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", bus.md_result); end
      bus.start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b want 0", bus.md_busy); end
      $display("reset test done");
   endtask

   task automatic test_decode();
      logic [6:0] opcs [4];
      logic [6:0] f7s [4];
      logic [3:0] exp_op;
      logic exp_md;
      opcs = '{7'h13, 7'h63, 7'h33, 7'h00};
      f7s  = '{7'h00, 7'h20, 7'h01, 7'h00};
      bus.start = 1'b0;
      // directed points
      bus.aluop_in = 2'b10; bus.instruction_opcode = 7'h33; bus.func7 = 7'h20; bus.func3 = 3'd5;
      #1 checks++;
      if (bus.aluop_out !== 4'b0011) begin errors++; $display("FAIL dec_sra got %b want 0011", bus.aluop_out); end
      bus.aluop_in = 2'b01; bus.instruction_opcode = 7'h63; bus.func7 = 7'h00; bus.func3 = 3'd6;
      #1 checks++;
      if (bus.aluop_out !== 4'b1101) begin errors++; $display("FAIL dec_bltu got %b want 1101", bus.aluop_out); end
      bus.aluop_in = 2'b10; bus.instruction_opcode = 7'h33; bus.func7 = 7'h01; bus.func3 = 3'd4;
      #1 checks += 2;
      if (bus.is_muldiv !== 1'b1) begin errors++; $display("FAIL dec_muldiv got %b want 1", bus.is_muldiv); end
      if (bus.aluop_out !== 4'b0010) begin errors++; $display("FAIL dec_muldiv_op got %b want 0010", bus.aluop_out); end
      // random sweep
      for (int i = 0; i < 300; i++) begin
         bus.aluop_in = 2'($urandom_range(0, 2));
         bus.instruction_opcode = ($urandom_range(0, 4) == 0) ? 7'($urandom) : opcs[$urandom_range(0, 2)];
         bus.func7 = ($urandom_range(0, 4) == 0) ? 7'($urandom) : f7s[$urandom_range(0, 2)];
         bus.func3 = 3'($urandom);
         #1;
         exp_op = model_alu(bus.aluop_in, bus.instruction_opcode, bus.func3, bus.func7);
         exp_md = (bus.instruction_opcode == 7'h33) && (bus.func7 == 7'h01);
         checks += 2;
         if (bus.aluop_out !== exp_op) begin
            errors++;
            $display("FAIL dec_sweep aop=%b opc=%b f3=%b f7=%b got %b want %b", bus.aluop_in,
                     bus.instruction_opcode, bus.func3, bus.func7, bus.aluop_out, exp_op);
         end
         if (bus.is_muldiv !== exp_md) begin
            errors++; $display("FAIL dec_is_muldiv opc=%b f7=%b got %b want %b",
                               bus.instruction_opcode, bus.func7, bus.is_muldiv, exp_md);
         end
      end
      $display("decode sweep done");
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 100));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_mul();
      check_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'h2, 0);
      check_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'h2, 0);
      for (int i = 0; i < 16; i++)
         check_op("mul_rand", 3'($urandom_range(0, 3)), pick_operand(), pick_operand(), 0);
   endtask

   task automatic test_div();
      logic [31:0] a, b;
      check_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'h2, 0);
      check_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'h2, 0);
      check_op("divu_zero", 3'd5, 32'h1234, 32'h0, 0);
      check_op("remu_zero", 3'd7, 32'h1234, 32'h0, 0);
      check_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      check_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      for (int i = 0; i < 16; i++) begin
         a = pick_operand();
         b = pick_operand();
         if ($urandom_range(0, 5) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         check_op("div_rand", 3'($urandom_range(4, 7)), a, b, 0);
      end
   endtask

   task automatic test_start_ignored();
      check_op("start_in_mul", 3'd0, 32'h0001_2345, 32'h0000_0777, 5);
      check_op("start_in_done", 3'd5, 32'hDEAD_BEEF, 32'h0000_0013, XLEN);
   endtask

   task automatic test_reset_abort();
      int dones;
      @(negedge clk);
      bus.start = 1'b1;
      bus.instruction_opcode = 7'h33;
      bus.func7 = 7'h01;
      bus.func3 = 3'd4;
      bus.aluop_in = 2'b10;
      bus.rs1 = 32'h0000_9999;
      bus.rs2 = 32'h0000_0007;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.md_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", bus.md_busy); end
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks += 3;
      if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.md_busy); end
      if (bus.md_done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", bus.md_done); end
      if (bus.md_result !== 32'h0) begin errors++; $display("FAIL abort_result got %h want 0", bus.md_result); end
      reset = 1'b1;
      dones = 0;
      for (int k = 0; k < 2 * XLEN; k++) begin
         @(negedge clk);
         if (bus.md_done) dones++;
      end
      checks++;
      if (dones != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", dones); end
      $display("reset abort test done dones=%0d", dones);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.instruction_opcode = 7'h0;
      bus.func3 = 3'd0;
      bus.func7 = 7'h0;
      bus.aluop_in = 2'b00;
      bus.rs1 = '0;
      bus.rs2 = '0;
      test_reset();
      test_decode();
      test_mul();
      test_div();
      test_start_ignored();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
